xdbl_cmd_sequencer: RTL and testbench

Command-issuing front end for `cryptoprocessor_wrapper_1506`. Accepts projective Montgomery point (X:Z) and curve constants (A:C) via a start handshake, loads them into the wrapper's register file, and issues the fixed 10-instruction xDBL program one command per cycle. It then reads back result slots 6 and 7 and presents both as redundant pairs (dout_1, dout_2). It is the driving end of the wrapper's `command_in` / `din` / `dout` interface, so the isogeny control layer no longer hand-sequences doublings.

---
 rtl/xdbl_cmd_sequencer.sv | 178 +++++++++++++++++
 tb/tb_xdbl_cmd_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xdbl_cmd_sequencer.sv
// xDBL command sequencer: loads X,Z,A,C into the cryptoprocessor wrapper, issues the 10-op program, reads slots 6/7.
// Latency 17+DRAIN_CYCLES+READ_LAT cycles from start to done; no backpressure, start is dropped unless idle.
module xdbl_cmd_sequencer #(
  parameter int W            = 1506,
  parameter int ADDR_W       = 7,
  parameter int DRAIN_CYCLES = 0,
  parameter int READ_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [W-1:0]          x_in,
  input  logic [W-1:0]          z_in,
  input  logic [W-1:0]          a_in,
  input  logic [W-1:0]          c_in,
  output logic                  busy,
  output logic                  done,
  output logic [W-1:0]          x_out_1,
  output logic [W-1:0]          x_out_2,
  output logic [W-1:0]          z_out_1,
  output logic [W-1:0]          z_out_2,
  output logic                  cp_get_output,
  output logic                  cp_data_en,
  output logic                  cp_ins_in,
  output logic [3+3*ADDR_W-1:0] cp_command,
  output logic [W-1:0]          cp_din_1,
  output logic [W-1:0]          cp_din_2,
  input  logic [W-1:0]          cp_dout_1,
  input  logic [W-1:0]          cp_dout_2
);

  localparam int CMD_W = 3 + 3*ADDR_W;
  localparam logic [2:0] INS_IDLE = 3'd0;
  localparam logic [2:0] INS_LOAD = 3'd1;
  localparam logic [2:0] INS_ADD  = 3'd3;
  localparam logic [2:0] INS_SUB  = 3'd4;
  localparam logic [2:0] INS_MUL  = 3'd5;
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES > 0 ? DRAIN_CYCLES - 1 : 0);
  localparam logic [7:0] X_CAP      = 8'(READ_LAT);
  localparam logic [7:0] Z_CAP      = 8'(READ_LAT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXEC, S_DRAIN, S_READ, S_DONE} state_t;

  state_t         state, state_nxt;
  logic [7:0]     cnt, cnt_nxt;
  logic [W-1:0]   x_r, z_r, a_r, c_r;

  function automatic logic [CMD_W-1:0] mk_cmd(input logic [2:0] ins, input int unsigned r1,
                                              input int unsigned r2, input int unsigned wr);
    return {ins, ADDR_W'(r1), ADDR_W'(r2), ADDR_W'(wr)};
  endfunction

  // Slots: 0=X 1=Z 2=A 3=C; results land in 6 (X2) and 7 (Z2).
  function automatic logic [CMD_W-1:0] exec_cmd(input logic [3:0] idx);
    case (idx)
      4'd0:    return mk_cmd(INS_SUB, 0, 1, 4);
      4'd1:    return mk_cmd(INS_ADD, 0, 1, 5);
      4'd2:    return mk_cmd(INS_MUL, 4, 4, 4);
      4'd3:    return mk_cmd(INS_MUL, 5, 5, 5);
      4'd4:    return mk_cmd(INS_MUL, 3, 4, 7);
      4'd5:    return mk_cmd(INS_MUL, 7, 5, 6);
      4'd6:    return mk_cmd(INS_SUB, 5, 4, 5);
      4'd7:    return mk_cmd(INS_MUL, 2, 5, 4);
      4'd8:    return mk_cmd(INS_ADD, 7, 4, 7);
      4'd9:    return mk_cmd(INS_MUL, 7, 5, 7);
      default: return mk_cmd(INS_IDLE, 0, 0, 0);
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      x_r <= x_in;
      z_r <= z_in;
      a_r <= a_in;
      c_r <= c_in;
    end
  end

  // Read data for issue n is sampled READ_LAT cycles after that issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_out_1 <= '0;
      x_out_2 <= '0;
      z_out_1 <= '0;
      z_out_2 <= '0;
    end else if (state == S_READ) begin
      if (cnt == X_CAP) begin
        x_out_1 <= cp_dout_1;
        x_out_2 <= cp_dout_2;
      end
      if (cnt == Z_CAP) begin
        z_out_1 <= cp_dout_1;
        z_out_2 <= cp_dout_2;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt + 8'd1;
    cp_get_output = 1'b0;
    cp_data_en    = 1'b0;
    cp_ins_in     = 1'b0;
    cp_command    = '0;
    cp_din_1      = '0;
    cp_din_2      = '0;
    case (state)
      S_IDLE: begin
        cnt_nxt = 8'd0;
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        cp_data_en = 1'b1;
        cp_ins_in  = 1'b1;
        cp_command = mk_cmd(INS_LOAD, 0, 0, int'(cnt[1:0]));
        case (cnt[1:0])
          2'd0:    cp_din_1 = x_r;
          2'd1:    cp_din_1 = z_r;
          2'd2:    cp_din_1 = a_r;
          default: cp_din_1 = c_r;
        endcase
        if (cnt == 8'd3) begin
          state_nxt = S_EXEC;
          cnt_nxt   = 8'd0;
        end
      end
      S_EXEC: begin
        cp_ins_in  = 1'b1;
        cp_command = exec_cmd(cnt[3:0]);
        if (cnt == 8'd9) begin
          state_nxt = (DRAIN_CYCLES > 0) ? S_DRAIN : S_READ;
          cnt_nxt   = 8'd0;
        end
      end
      S_DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_nxt = S_READ;
          cnt_nxt   = 8'd0;
        end
      end
      S_READ: begin
        if (cnt == 8'd0) begin
          cp_get_output = 1'b1;
          cp_command    = mk_cmd(INS_IDLE, 6, 0, 0);
        end else if (cnt == 8'd1) begin
          cp_get_output = 1'b1;
          cp_command    = mk_cmd(INS_IDLE, 7, 0, 0);
        end
        if (cnt == Z_CAP) begin
          state_nxt = S_DONE;
          cnt_nxt   = 8'd0;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 8'd0;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  assign busy = (state != S_IDLE) && (state != S_DONE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_xdbl_cmd_sequencer.sv
// Bench for xdbl_cmd_sequencer: default instance against a behavioural register-file stub,
// plus a DRAIN_CYCLES=2 / READ_LAT=2 instance against an address-echo stub.
module tb_xdbl_cmd_sequencer;
  localparam int W = 1506;
  localparam logic [W-1:0] K = W'(64'hDEAD_BEEF_0BAD_F00D) << 700;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, start2;
  logic [W-1:0] x_in, z_in, a_in, c_in;

  logic busy, done, cp_get_output, cp_data_en, cp_ins_in;
  logic [23:0] cp_command;
  logic [W-1:0] x_out_1, x_out_2, z_out_1, z_out_2, cp_din_1, cp_din_2, cp_dout_1, cp_dout_2;

  logic d2_busy, d2_done, d2_get, d2_den, d2_ins;
  logic [23:0] d2_cmd;
  logic [W-1:0] d2_x_out_1, d2_x_out_2, d2_z_out_1, d2_z_out_2, d2_din_1, d2_din_2, d2_dout_1, d2_dout_2;

  xdbl_cmd_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .x_in(x_in), .z_in(z_in), .a_in(a_in), .c_in(c_in),
    .busy(busy), .done(done),
    .x_out_1(x_out_1), .x_out_2(x_out_2), .z_out_1(z_out_1), .z_out_2(z_out_2),
    .cp_get_output(cp_get_output), .cp_data_en(cp_data_en), .cp_ins_in(cp_ins_in),
    .cp_command(cp_command), .cp_din_1(cp_din_1), .cp_din_2(cp_din_2),
    .cp_dout_1(cp_dout_1), .cp_dout_2(cp_dout_2)
  );

  xdbl_cmd_sequencer #(.DRAIN_CYCLES(2), .READ_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .x_in(x_in), .z_in(z_in), .a_in(a_in), .c_in(c_in),
    .busy(d2_busy), .done(d2_done),
    .x_out_1(d2_x_out_1), .x_out_2(d2_x_out_2), .z_out_1(d2_z_out_1), .z_out_2(d2_z_out_2),
    .cp_get_output(d2_get), .cp_data_en(d2_den), .cp_ins_in(d2_ins),
    .cp_command(d2_cmd), .cp_din_1(d2_din_1), .cp_din_2(d2_din_2),
    .cp_dout_1(d2_dout_1), .cp_dout_2(d2_dout_2)
  );

  // Wrapper stub: register file with plain mod-2^W arithmetic, one-cycle read latency,
  // results returned as the redundant pair (v-K, K).
  logic [W-1:0] rf [0:127];
  logic [2:0] s_ins;
  logic [6:0] s_rd1, s_rd2, s_wr;
  assign s_ins = cp_command[23:21];
  assign s_rd1 = cp_command[20:14];
  assign s_rd2 = cp_command[13:7];
  assign s_wr  = cp_command[6:0];

  always @(posedge clk) begin
    if (cp_ins_in) begin
      case (s_ins)
        3'd1: if (cp_data_en) rf[s_wr] <= cp_din_1 + cp_din_2;
        3'd2: rf[s_wr] <= rf[s_rd1];
        3'd3: rf[s_wr] <= rf[s_rd1] + rf[s_rd2];
        3'd4: rf[s_wr] <= rf[s_rd1] - rf[s_rd2];
        3'd5: rf[s_wr] <= rf[s_rd1] * rf[s_rd2];
        default: ;
      endcase
    end
    if (cp_get_output) begin
      cp_dout_1 <= rf[s_rd1] - K;
      cp_dout_2 <= K;
    end
  end

  // Second stub echoes the read address two cycles after issue.
  logic [6:0] p1, p2;
  always @(posedge clk) begin
    p1 <= d2_get ? d2_cmd[20:14] : 7'd0;
    p2 <= p1;
  end
  assign d2_dout_1 = W'(p2);
  assign d2_dout_2 = '0;

  logic [28:0] ctrl;
  assign ctrl = {cp_command, cp_data_en, cp_ins_in, cp_get_output, busy, done};

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got ..%h expected ..%h (low 64 bits)", nm, act[63:0], exp[63:0]);
    end
  endtask

  function automatic void xdbl_ref(input logic [W-1:0] x, input logic [W-1:0] z,
                                   input logic [W-1:0] a, input logic [W-1:0] c,
                                   output logic [W-1:0] xd, output logic [W-1:0] zd);
    logic [W-1:0] t1, t2, diff;
    t1   = (x - z) * (x - z);
    t2   = (x + z) * (x + z);
    diff = t2 - t1;
    xd   = c * t1 * t2;
    zd   = (c * t1 + a * diff) * diff;
  endfunction

  logic [W-1:0] sx [3], sz [3], sa [3], sc [3], ex [3], ez [3];

  task automatic set_ops(input int s);
    x_in = sx[s];
    z_in = sz[s];
    a_in = sa[s];
    c_in = sc[s];
  endtask

  function automatic logic [W-1:0] din_exp(input logic [2:0] sel);
    case (sel)
      3'd1:    return sx[0];
      3'd2:    return sz[0];
      3'd3:    return sa[0];
      3'd4:    return sc[0];
      default: return '0;
    endcase
  endfunction

  typedef struct packed {
    logic        start;
    logic        opsel;
    logic [23:0] cmd;
    logic [2:0]  din;
    logic        den;
    logic        ins;
    logic        get;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t        tv [21];
  logic [23:0] prog [10];

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        cyc = k;
        break;
      end
    end
  endtask

  initial begin
    int n_done;
    int cyc;

    sx[0] = (W'(1) << 1500) | W'(64'h0123_4567_89AB_CDEF);
    sz[0] = W'(467);
    sa[0] = W'(8);
    sc[0] = W'(4);
    sx[1] = W'(5);
    sz[1] = W'(9);
    sa[1] = W'(1);
    sc[1] = W'(2);
    sx[2] = '1;
    sz[2] = (W'(1) << 777) | W'(3);
    sa[2] = W'(8);
    sc[2] = W'(4);
    for (int s = 0; s < 3; s++) xdbl_ref(sx[s], sz[s], sa[s], sc[s], ex[s], ez[s]);

    prog = '{{3'd4, 7'd0, 7'd1, 7'd4}, {3'd3, 7'd0, 7'd1, 7'd5}, {3'd5, 7'd4, 7'd4, 7'd4},
             {3'd5, 7'd5, 7'd5, 7'd5}, {3'd5, 7'd3, 7'd4, 7'd7}, {3'd5, 7'd7, 7'd5, 7'd6},
             {3'd4, 7'd5, 7'd4, 7'd5}, {3'd5, 7'd2, 7'd5, 7'd4}, {3'd3, 7'd7, 7'd4, 7'd7},
             {3'd5, 7'd7, 7'd5, 7'd7}};

    // Cycle 0 = acceptance cycle; start also pulsed at 3, 10 and 18 (DONE) with other operands.
    for (int i = 0; i < 21; i++) tv[i] = '0;
    for (int i = 1; i <= 17; i++) tv[i].busy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tv[i].den = 1'b1;
      tv[i].ins = 1'b1;
      tv[i].din = 3'(i);
      tv[i].cmd = {3'd1, 7'd0, 7'd0, 7'(i - 1)};
    end
    for (int i = 0; i < 10; i++) begin
      tv[5 + i].ins = 1'b1;
      tv[5 + i].cmd = prog[i];
    end
    tv[15].get = 1'b1;
    tv[15].cmd = {3'd0, 7'd6, 7'd0, 7'd0};
    tv[16].get = 1'b1;
    tv[16].cmd = {3'd0, 7'd7, 7'd0, 7'd0};
    tv[18].done  = 1'b1;
    tv[0].start  = 1'b1;
    tv[3].start  = 1'b1;
    tv[3].opsel  = 1'b1;
    tv[10].start = 1'b1;
    tv[10].opsel = 1'b1;
    tv[18].start = 1'b1;
    tv[18].opsel = 1'b1;

    rst = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    set_ops(0);
    repeat (2) @(negedge clk);
    chk("reset_ctrl", 64'(ctrl), 64'd0);
    chkw("reset_din1", cp_din_1, '0);
    chkw("reset_xout1", x_out_1, '0);
    chkw("reset_zout2", z_out_2, '0);
    chk("reset_dut2", {d2_busy, d2_done, d2_get, d2_den, d2_ins}, 64'd0);
    rst = 1'b0;

    n_done = 0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      chk($sformatf("ctrl_c%0d", i), 64'(ctrl),
          64'({tv[i].cmd, tv[i].den, tv[i].ins, tv[i].get, tv[i].busy, tv[i].done}));
      chkw($sformatf("din1_c%0d", i), cp_din_1, din_exp(tv[i].din));
      chkw($sformatf("din2_c%0d", i), cp_din_2, '0);
      if (done) n_done++;
      start = tv[i].start;
      if (tv[i].start) set_ops(int'(tv[i].opsel));
    end
    start = 1'b0;
    chk("single_done", 64'(n_done), 64'd1);
    chkw("run0_x", x_out_1 + x_out_2, ex[0]);
    chkw("run0_z", z_out_1 + z_out_2, ez[0]);
    chkw("run0_x2", x_out_2, K);

    // Reset while EXEC is under way.
    @(negedge clk);
    set_ops(2);
    start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 9) rst = 1'b1;
    end
    @(negedge clk);
    chk("rst_ctrl", 64'(ctrl), 64'd0);
    chkw("rst_din1", cp_din_1, '0);
    chkw("rst_xout1", x_out_1, '0);
    chkw("rst_xout2", x_out_2, '0);
    chkw("rst_zout1", z_out_1, '0);
    chkw("rst_zout2", z_out_2, '0);
    rst = 1'b0;
    start = 1'b1;
    wait_done(cyc);
    chk("rst_rerun_lat", 64'(cyc), 64'd18);
    chkw("rst_rerun_x", x_out_1 + x_out_2, ex[2]);
    chkw("rst_rerun_z", z_out_1 + z_out_2, ez[2]);

    // Back-to-back: start in the cycle right after done.
    @(negedge clk);
    set_ops(1);
    start = 1'b1;
    cyc = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 10) begin
        chkw("b2b_hold_x", x_out_1 + x_out_2, ex[2]);
        chkw("b2b_hold_z", z_out_1 + z_out_2, ez[2]);
      end
      if (done) begin
        cyc = k;
        break;
      end
    end
    chk("b2b_lat", 64'(cyc), 64'd18);
    chkw("b2b_x", x_out_1 + x_out_2, ex[1]);
    chkw("b2b_z", z_out_1 + z_out_2, ez[1]);

    // Drain and read-latency parameters on the second instance.
    @(negedge clk);
    start2 = 1'b1;
    cyc = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (k == 20) chk("lat_busy_c20", 64'({d2_busy, d2_done}), 64'b10);
      if (d2_done) begin
        cyc = k;
        break;
      end
    end
    chk("lat_done_cycle", 64'(cyc), 64'd21);
    chkw("lat_x_out_1", d2_x_out_1, W'(6));
    chkw("lat_z_out_1", d2_z_out_1, W'(7));
    chkw("lat_x_out_2", d2_x_out_2, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
